store_monitor: RTL and testbench
================================

# store_monitor

Synthesizable store-bus responder for the single-cycle RISC-V core's data-memory interface (MemWrite, DataAdr, WriteData). It sits beside data memory on the store bus and snoops every store. It classifies the program outcome as PASS, FAIL or TIMEOUT and holds a sticky verdict plus the offending store for hardware/FPGA self-test. It replaces the bench-side pass/fail check with registered on-chip logic.

## Interface

**Parameters**
- PASS_ADR, 32'd100: address whose store signals end of program.
- PASS_DATA, 32'd25: value that must be stored to PASS_ADR for a pass.
- SCRATCH_BASE, 32'd96: first byte address of the permitted scratch window.
- SCRATCH_SIZE, 32'd4: window size in bytes; 0 disables the window.
- TIMEOUT_CYCLES, 1000: cycles in RUN before TIMEOUT; 0 disables timeout.
- COUNT_W, 16: width of the store counter.

**Ports**
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- MemWrite, in, 1: store strobe from the core, sampled at the rising edge.
- DataAdr, in, 32: store address.
- WriteData, in, 32: store data.
- done, out, 1: verdict reached (state is not RUN).
- pass, out, 1: state is PASS.
- fail, out, 1: state is FAIL.
- timeout, out, 1: state is TIMEOUT.
- store_count, out, COUNT_W: number of stores accepted in RUN; saturates at all-ones.
- last_adr, out, 32: address of the most recent store accepted in RUN.
- last_data, out, 32: data of the most recent store accepted in RUN.

## Operation

**States:** RUN, PASS, FAIL, TIMEOUT.

**Reset.** While reset is high at a rising edge:
- state goes to RUN.
- done, pass, fail and timeout are 0.
- store_count, last_adr and last_data are 0.
- The cycle counter is cleared.

**RUN, store sampled (MemWrite = 1).** Classify the store in this priority order:
1. DataAdr == PASS_ADR and WriteData == PASS_DATA: go to PASS.
2. DataAdr == PASS_ADR with any other data: go to FAIL.
3. DataAdr in [SCRATCH_BASE, SCRATCH_BASE+SCRATCH_SIZE): stay in RUN.
4. Any other address: go to FAIL.

On every store in RUN, whatever its class:
- store_count increments (saturating).
- last_adr and last_data capture the store.

The window comparison is unsigned 32-bit, with the upper bound computed in 33 bits so that wrap-around does not alias.

**RUN, cycle counter.**
- Increments every cycle spent in RUN.
- When it reaches TIMEOUT_CYCLES-1 with no verdict-producing store in that same cycle, the state goes to TIMEOUT.
- If a terminal store and the timeout coincide, the store classification wins.

**Terminal states (PASS, FAIL, TIMEOUT).**
- Sticky until reset.
- Further stores are ignored: no change to the counter, last_adr or last_data.
- The cycle counter freezes.

**Reset mid-operation.** Reset asserted in any state, including a cycle with MemWrite high, takes priority. The next state is the clean reset condition and the store is not counted.

## Timing

- All outputs are registered. The verdict is visible in the cycle after the rising edge that sampled the deciding store (one-cycle latency).
- pass, fail, timeout and done are decoded from state registers and are glitch-free.
- Exactly one of pass, fail or timeout is high whenever done is high.
- For a store on rising edge N, store_count, last_adr and last_data are updated in the cycle after edge N, together with the verdict.
- Inputs are assumed stable at the rising edge (the core drives them combinationally from the previous edge).
- Throughput: one store per cycle, with no back-pressure. There is no ready signal, because the core's stores are always accepted.

## Structure

**Package store_monitor_pkg holds:**
- The state enum (RUN, PASS, FAIL, TIMEOUT).
- The store-class enum (CLS_PASS, CLS_BADDATA, CLS_SCRATCH, CLS_ILLEGAL).
- Default constants for the pass address, pass data and scratch window, shared with the bench.

**Sub-module cycle_timer:**
- Parameters: a width and a limit (0 = disabled).
- Inputs: clk, reset, enable.
- Output: an expired pulse, asserted combinationally on the final count.

**Top level contains:**
- The classifier (combinational).
- The FSM.
- The saturating counter and capture registers.

## Test plan

1. **Pass after scratch.**
   - Stimulus: reset for 2 cycles, then a store of 7 to 96, then idle cycles, then a store of 25 to 100.
   - Required: pass=1 and done=1 one cycle after the second store; store_count=2; last_adr=100; last_data=25.
2. **Wrong data at PASS_ADR.**
   - Stimulus: a store of 24 to 100.
   - Required: fail=1 next cycle; last_data=24; a later store of 25 to 100 leaves fail=1 and store_count=1.
3. **Illegal address.**
   - Stimulus: a store of 25 to 104.
   - Required: fail=1; last_adr=104.
   - Sub-case with SCRATCH_SIZE=0: a store of 7 to 96 also gives fail=1.
4. **Timeout.**
   - Stimulus: TIMEOUT_CYCLES=20 and no stores.
   - Required: timeout=1 after exactly 20 RUN cycles (not at 19).
   - With TIMEOUT_CYCLES=0, no timeout occurs after 2000 cycles.
5. **Store coinciding with the timeout.**
   - Stimulus: a store of 25 to 100 on the 20th cycle.
   - Required: pass=1 and timeout=0.
6. **Reset mid-operation.**
   - Stimulus: reset asserted in PASS, and separately reset asserted in a cycle with MemWrite=1 to 96.
   - Required: next cycle is RUN; all outputs are 0; store_count=0.
   - Also check saturation with COUNT_W=2: five scratch stores give store_count=3.

Source files
------------

// File: rtl/store_monitor_pkg.sv
`default_nettype none
// ============================================================================
// store_monitor_pkg : shared types and default constants for store_monitor
// Rev 1.0
// ============================================================================
package store_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_PASS    = 2'd0,
    CLS_BADDATA = 2'd1,
    CLS_SCRATCH = 2'd2,
    CLS_ILLEGAL = 2'd3
  } store_cls_e;

  localparam logic [31:0] DEF_PASS_ADR     = 32'd100;
  localparam logic [31:0] DEF_PASS_DATA    = 32'd25;
  localparam logic [31:0] DEF_SCRATCH_BASE = 32'd96;
  localparam logic [31:0] DEF_SCRATCH_SIZE = 32'd4;

endpackage
`default_nettype wire

// File: rtl/store_monitor_cycle_timer.sv
`default_nettype none
// ============================================================================
// cycle_timer : counts enabled cycles, pulses expired on the final count
// Rev 1.0
// ============================================================================
module cycle_timer #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned LIMIT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic expired
);

  if (LIMIT == 0) begin : g_disabled
    logic unused_inputs;
    assign unused_inputs = clk ^ reset ^ enable;
    assign expired       = 1'b0;
  end else begin : g_enabled
    localparam logic [WIDTH-1:0] C_LAST = WIDTH'(LIMIT - 1);
    logic [WIDTH-1:0] cnt_q;

    assign expired = enable && (cnt_q == C_LAST);

    // Holding at the final count keeps the value meaningful once frozen.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (enable && !expired) begin
        cnt_q <= cnt_q + WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/store_monitor.sv
`default_nettype none
// ============================================================================
// store_monitor : snoops core stores and latches a sticky PASS/FAIL/TIMEOUT
// Rev 1.0
// ============================================================================
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter logic [31:0] PASS_ADR       = DEF_PASS_ADR,
  parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
  parameter logic [31:0] SCRATCH_BASE   = DEF_SCRATCH_BASE,
  parameter logic [31:0] SCRATCH_SIZE   = DEF_SCRATCH_SIZE,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned COUNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MemWrite,
  input  logic [31:0]        DataAdr,
  input  logic [31:0]        WriteData,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [COUNT_W-1:0] store_count,
  output logic [31:0]        last_adr,
  output logic [31:0]        last_data
);

  localparam int unsigned C_TMR_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // 33-bit upper bound so a window touching the top of memory cannot wrap to 0.
  localparam logic [32:0] C_WIN_LO = {1'b0, SCRATCH_BASE};
  localparam logic [32:0] C_WIN_HI = {1'b0, SCRATCH_BASE} + {1'b0, SCRATCH_SIZE};

  state_e             state_q;
  store_cls_e         cls;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic [31:0]        last_adr_q;
  logic [31:0]        last_data_q;
  logic               tmr_expired;
  logic               in_run;

  assign in_run = (state_q == ST_RUN);

  always_comb begin
    cls = CLS_ILLEGAL;
    if (DataAdr == PASS_ADR) begin
      cls = (WriteData == PASS_DATA) ? CLS_PASS : CLS_BADDATA;
    end else if (({1'b0, DataAdr} >= C_WIN_LO) && ({1'b0, DataAdr} < C_WIN_HI)) begin
      cls = CLS_SCRATCH;
    end
  end

  assign count_d = (count_q == '1) ? count_q : count_q + COUNT_W'(1);

  cycle_timer #(
    .WIDTH (C_TMR_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .enable  (in_run),
    .expired (tmr_expired)
  );

  // A deciding store in the same cycle as expiry takes precedence over timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      count_q     <= '0;
      last_adr_q  <= '0;
      last_data_q <= '0;
    end else if (in_run) begin
      if (MemWrite) begin
        count_q     <= count_d;
        last_adr_q  <= DataAdr;
        last_data_q <= WriteData;
      end
      if (MemWrite && (cls == CLS_PASS)) begin
        state_q <= ST_PASS;
      end else if (MemWrite && (cls != CLS_SCRATCH)) begin
        state_q <= ST_FAIL;
      end else if (tmr_expired) begin
        state_q <= ST_TIMEOUT;
      end
    end
  end

  assign done        = (state_q != ST_RUN);
  assign pass        = (state_q == ST_PASS);
  assign fail        = (state_q == ST_FAIL);
  assign timeout     = (state_q == ST_TIMEOUT);
  assign store_count = count_q;
  assign last_adr    = last_adr_q;
  assign last_data   = last_data_q;

endmodule
`default_nettype wire

// File: tb/tb_store_monitor.sv
`default_nettype none
// ============================================================================
// tb_store_monitor : directed + random checks of three store_monitor configs
// Rev 1.0
// ============================================================================
module tb_store_monitor;
  import store_monitor_pkg::*;

  // Reference-model verdicts
  localparam int M_RUN = 0, M_PASS = 1, M_FAIL = 2, M_TO = 3;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mw  = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wd  = '0;

  always #5 clk = ~clk;

  // u0: timeout 20, wide count; u1: no window, no timeout, 2-bit count;
  // u2: default window, no timeout, 2-bit count.
  logic        dn0, ps0, fl0, to0, dn1, ps1, fl1, to1, dn2, ps2, fl2, to2;
  logic [15:0] cnt0;
  logic [1:0]  cnt1, cnt2;
  logic [31:0] la0, ld0, la1, ld1, la2, ld2;

  store_monitor #(.TIMEOUT_CYCLES(20), .COUNT_W(16)) u0 (
    .clk(clk), .reset(rst), .MemWrite(mw), .DataAdr(adr), .WriteData(wd),
    .done(dn0), .pass(ps0), .fail(fl0), .timeout(to0),
    .store_count(cnt0), .last_adr(la0), .last_data(ld0));

  store_monitor #(.SCRATCH_SIZE(32'd0), .TIMEOUT_CYCLES(0), .COUNT_W(2)) u1 (
    .clk(clk), .reset(rst), .MemWrite(mw), .DataAdr(adr), .WriteData(wd),
    .done(dn1), .pass(ps1), .fail(fl1), .timeout(to1),
    .store_count(cnt1), .last_adr(la1), .last_data(ld1));

  store_monitor #(.TIMEOUT_CYCLES(0), .COUNT_W(2)) u2 (
    .clk(clk), .reset(rst), .MemWrite(mw), .DataAdr(adr), .WriteData(wd),
    .done(dn2), .pass(ps2), .fail(fl2), .timeout(to2),
    .store_count(cnt2), .last_adr(la2), .last_data(ld2));

  int          cfg_tmo  [NI] = '{20, 0, 0};
  longint      cfg_size [NI] = '{4, 0, 4};
  longint      cfg_cmax [NI] = '{65535, 3, 3};

  int          m_st  [NI];
  longint      m_cnt [NI];
  int          m_run [NI];
  logic [31:0] m_la  [NI];
  logic [31:0] m_ld  [NI];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Behavioural rules: verdict from the store, timeout after N RUN cycles.
  task automatic model_step(input int i, input logic r, input logic we,
                            input logic [31:0] a, input logic [31:0] d);
    int nxt;
    if (r) begin
      m_st[i] = M_RUN; m_cnt[i] = 0; m_run[i] = 0; m_la[i] = '0; m_ld[i] = '0;
      return;
    end
    if (m_st[i] != M_RUN) return;
    m_run[i]++;
    nxt = M_RUN;
    if (we) begin
      m_cnt[i] = (m_cnt[i] < cfg_cmax[i]) ? m_cnt[i] + 1 : cfg_cmax[i];
      m_la[i]  = a;
      m_ld[i]  = d;
      if (a == DEF_PASS_ADR)
        nxt = (d == DEF_PASS_DATA) ? M_PASS : M_FAIL;
      else if (!(longint'(a) >= 96 && longint'(a) < 96 + cfg_size[i]))
        nxt = M_FAIL;
    end
    if (nxt == M_RUN && cfg_tmo[i] != 0 && m_run[i] == cfg_tmo[i]) nxt = M_TO;
    m_st[i] = nxt;
  endtask

  task automatic check_inst(input int i, input logic dn, input logic ps, input logic fl,
                            input logic to, input logic [63:0] cnt,
                            input logic [31:0] la, input logic [31:0] ld);
    chk($sformatf("u%0d.done", i),    {63'd0, dn}, {63'd0, m_st[i] != M_RUN});
    chk($sformatf("u%0d.pass", i),    {63'd0, ps}, {63'd0, m_st[i] == M_PASS});
    chk($sformatf("u%0d.fail", i),    {63'd0, fl}, {63'd0, m_st[i] == M_FAIL});
    chk($sformatf("u%0d.timeout", i), {63'd0, to}, {63'd0, m_st[i] == M_TO});
    chk($sformatf("u%0d.count", i),   cnt, 64'(m_cnt[i]));
    chk($sformatf("u%0d.last_adr", i),  {32'd0, la}, {32'd0, m_la[i]});
    chk($sformatf("u%0d.last_data", i), {32'd0, ld}, {32'd0, m_ld[i]});
  endtask

  task automatic cycle(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    rst = r; mw = we; adr = a; wd = d;
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i, r, we, a, d);
    #1;
    check_inst(0, dn0, ps0, fl0, to0, 64'(cnt0), la0, ld0);
    check_inst(1, dn1, ps1, fl1, to1, 64'(cnt1), la1, ld1);
    check_inst(2, dn2, ps2, fl2, to2, 64'(cnt2), la2, ld2);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [31:0] ra, rd;

    // Pass after scratch
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0);
    chk("reset.done", {63'd0, dn0}, 64'd0);
    chk("reset.count", 64'(cnt0), 64'd0);
    cycle(1'b0, 1'b1, 32'd96, 32'd7);
    idle(3);
    cycle(1'b0, 1'b1, 32'd100, 32'd25);
    chk("t1.pass", {63'd0, ps0}, 64'd1);
    chk("t1.done", {63'd0, dn0}, 64'd1);
    chk("t1.count", 64'(cnt0), 64'd2);
    chk("t1.last_adr", {32'd0, la0}, 64'd100);
    chk("t1.last_data", {32'd0, ld0}, 64'd25);

    // Wrong data at the pass address, then stickiness
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 32'd100, 32'd24);
    chk("t2.fail", {63'd0, fl0}, 64'd1);
    chk("t2.last_data", {32'd0, ld0}, 64'd24);
    cycle(1'b0, 1'b1, 32'd100, 32'd25);
    chk("t2.sticky_fail", {63'd0, fl0}, 64'd1);
    chk("t2.sticky_count", 64'(cnt0), 64'd1);

    // Illegal address; empty window
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 32'd104, 32'd25);
    chk("t3.fail", {63'd0, fl0}, 64'd1);
    chk("t3.last_adr", {32'd0, la0}, 64'd104);
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 32'd96, 32'd7);
    chk("t3.nowin_fail", {63'd0, fl1}, 64'd1);
    chk("t3.win_run", {63'd0, dn0}, 64'd0);

    // Timeout exactly at 20 RUN cycles; none when disabled
    cycle(1'b1, 1'b0, '0, '0);
    idle(19);
    chk("t4.no_to_at_19", {63'd0, to0}, 64'd0);
    idle(1);
    chk("t4.to_at_20", {63'd0, to0}, 64'd1);
    idle(1980);
    chk("t4.disabled_to", {63'd0, to2}, 64'd0);
    chk("t4.disabled_done", {63'd0, dn2}, 64'd0);

    // Store coinciding with expiry
    cycle(1'b1, 1'b0, '0, '0);
    idle(19);
    cycle(1'b0, 1'b1, 32'd100, 32'd25);
    chk("t5.pass", {63'd0, ps0}, 64'd1);
    chk("t5.timeout", {63'd0, to0}, 64'd0);

    // Reset in PASS, reset with a store present, saturation
    cycle(1'b1, 1'b0, '0, '0);
    chk("t6.rst_pass_done", {63'd0, dn0}, 64'd0);
    cycle(1'b0, 1'b1, 32'd96, 32'd7);
    cycle(1'b1, 1'b1, 32'd96, 32'd7);
    chk("t6.rst_store_count", 64'(cnt0), 64'd0);
    chk("t6.rst_store_adr", {32'd0, la0}, 64'd0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 32'd96 + 32'(k % 4), 32'd7);
    chk("t6.sat_count", 64'(cnt2), 64'd3);
    chk("t6.wide_count", 64'(cnt0), 64'd5);

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      case ($urandom_range(0, 5))
        0: ra = 32'd100;
        1: ra = 32'd96 + 32'($urandom_range(0, 3));
        2: ra = 32'd95;
        3: ra = 32'd104;
        4: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      rd = ($urandom_range(0, 1) == 1) ? 32'd25 : 32'($urandom_range(0, 40));
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, ra, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
